// File: rtl/sram_port_arbiter_pkg.sv
// rtl/sram_port_arbiter_pkg.sv - shared types and width helpers for the SRAM port arbiter
package sram_port_arbiter_pkg;

  typedef enum logic {
    LOCK_NONE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_e;

  // Index width that never collapses to zero bits for tiny port counts.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_arb_rr_pick.sv
// rtl/sram_arb_rr_pick.sv - combinational rotate-priority picker
// Returns the first requesting port at or above ptr_i, wrapping at N_PORTS.
module sram_arb_rr_pick #(
  parameter int N_PORTS = 2,
  parameter int PW      = 1
) (
  input  logic [N_PORTS-1:0] req_i,
  input  logic [PW-1:0]      ptr_i,
  output logic [N_PORTS-1:0] gnt_o,
  output logic [PW-1:0]      idx_o
);

  logic        found;
  logic [PW:0] pos;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      pos = {1'b0, ptr_i} + (PW+1)'(i);
      if (pos >= (PW+1)'(N_PORTS)) begin
        pos = pos - (PW+1)'(N_PORTS);
      end
      if (!found && req_i[pos[PW-1:0]]) begin
        found                = 1'b1;
        gnt_o[pos[PW-1:0]]   = 1'b1;
        idx_o                = pos[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - round-robin arbiter sharing one synchronous SRAM among N_PORTS
// Supports bounded burst locking; read data returns one cycle after grant.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter  int N_PORTS   = 2,
  parameter  int WIDTH     = 32,
  parameter  int DEPTH     = 512,
  parameter  int MAX_BURST = 4,
  localparam int AW        = $clog2(DEPTH),
  localparam int BW        = WIDTH / 8,
  localparam int PW        = idx_width(N_PORTS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [N_PORTS-1:0]    req_i,
  input  logic [N_PORTS-1:0]    lock_i,
  output logic [N_PORTS-1:0]    gnt_o,
  input  logic [N_PORTS-1:0]    we_i,
  input  logic [N_PORTS*BW-1:0] be_i,
  input  logic [N_PORTS*AW-1:0] addr_i,
  input  logic [N_PORTS*WIDTH-1:0] wdata_i,
  output logic [N_PORTS-1:0]    rvalid_o,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  ram_cs_n_o,
  output logic                  ram_we_n_o,
  output logic [BW-1:0]         ram_be_n_o,
  output logic [AW-1:0]         ram_addr_o,
  output logic [WIDTH-1:0]      ram_wdata_o,
  input  logic [WIDTH-1:0]      ram_rdata_i
);

  localparam int            CW      = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

  lock_state_e         lock_q, lock_d;
  logic [PW-1:0]       owner_q, owner_d;
  logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [N_PORTS-1:0]  rvalid_q;

  logic [N_PORTS-1:0]  rr_gnt, lock_gnt;
  logic [PW-1:0]       rr_idx, win_idx, win_nxt;
  logic                locked_pick;

  logic                we_sel;
  logic [BW-1:0]       be_sel;
  logic [AW-1:0]       addr_sel;
  logic [WIDTH-1:0]    wdata_sel;

  sram_arb_rr_pick #(
    .N_PORTS (N_PORTS),
    .PW      (PW)
  ) u_rr_pick (
    .req_i (req_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (rr_gnt),
    .idx_o (rr_idx)
  );

  always_comb begin
    lock_gnt          = '0;
    lock_gnt[owner_q] = 1'b1;
    locked_pick       = (lock_q == LOCK_HELD) && req_i[owner_q] && (cnt_q < MAX_CNT);
    win_idx           = locked_pick ? owner_q : rr_idx;
    win_nxt           = (win_idx == PW'(N_PORTS - 1)) ? '0 : win_idx + 1'b1;
    if (rst_i) begin
      gnt_o = '0;
    end else if (locked_pick) begin
      gnt_o = lock_gnt;
    end else begin
      gnt_o = rr_gnt;
    end
  end

  // AND-OR mux: with no grant every selected field is zero, which idles the SRAM pins.
  always_comb begin
    we_sel    = 1'b0;
    be_sel    = '0;
    addr_sel  = '0;
    wdata_sel = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      we_sel    = we_sel    | (we_i[p] & gnt_o[p]);
      be_sel    = be_sel    | (be_i[p*BW +: BW] & {BW{gnt_o[p]}});
      addr_sel  = addr_sel  | (addr_i[p*AW +: AW] & {AW{gnt_o[p]}});
      wdata_sel = wdata_sel | (wdata_i[p*WIDTH +: WIDTH] & {WIDTH{gnt_o[p]}});
    end
  end

  assign ram_cs_n_o  = ~(|gnt_o);
  assign ram_we_n_o  = ~we_sel;
  assign ram_be_n_o  = ~be_sel;
  assign ram_addr_o  = addr_sel;
  assign ram_wdata_o = wdata_sel;
  assign rvalid_o    = rvalid_q;
  assign rdata_o     = ram_rdata_i;

  always_comb begin
    lock_d   = lock_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    cnt_inc  = locked_pick ? cnt_q + 1'b1 : CW'(1);
    if (|req_i) begin
      if (!locked_pick) begin
        rr_ptr_d = win_nxt;
      end
      if (lock_i[win_idx]) begin
        if (cnt_inc >= MAX_CNT) begin
          // Exhausted burst: drop the lock and put this port last in rotation.
          lock_d   = LOCK_NONE;
          owner_d  = '0;
          cnt_d    = '0;
          rr_ptr_d = win_nxt;
        end else begin
          lock_d   = LOCK_HELD;
          owner_d  = win_idx;
          cnt_d    = cnt_inc;
        end
      end else begin
        lock_d  = LOCK_NONE;
        owner_d = '0;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_q   <= LOCK_NONE;
      owner_q  <= '0;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
      rvalid_q <= '0;
    end else begin
      lock_q   <= lock_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      rvalid_q <= gnt_o & ~we_i;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - self-checking bench for sram_port_arbiter
module tb_sram_port_arbiter;

  localparam int N  = 2;
  localparam int W  = 32;
  localparam int D  = 512;
  localparam int MB = 4;
  localparam int AW = 9;
  localparam int BW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req, lock, gnt, we, rvalid;
  logic [N*BW-1:0]   be;
  logic [N*AW-1:0]   addr;
  logic [N*W-1:0]    wdata;
  logic [W-1:0]      rdata, ram_wdata, ram_rdata;
  logic              ram_cs_n, ram_we_n;
  logic [BW-1:0]     ram_be_n;
  logic [AW-1:0]     ram_addr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.N_PORTS(N), .WIDTH(W), .DEPTH(D), .MAX_BURST(MB)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .lock_i(lock), .gnt_o(gnt),
    .we_i(we), .be_i(be), .addr_i(addr), .wdata_i(wdata),
    .rvalid_o(rvalid), .rdata_o(rdata),
    .ram_cs_n_o(ram_cs_n), .ram_we_n_o(ram_we_n), .ram_be_n_o(ram_be_n),
    .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  // Behavioural single-port SRAM with one-cycle read latency.
  logic [W-1:0] sram [D];
  logic [W-1:0] sram_q;
  always @(posedge clk) begin
    if (!ram_cs_n) begin
      if (!ram_we_n) begin
        for (int b = 0; b < BW; b++)
          if (!ram_be_n[b]) sram[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      end else begin
        sram_q <= sram[ram_addr];
      end
    end
  end
  assign ram_rdata = sram_q;

  // Reference model state: arbitration rules and expected memory contents.
  int           m_rr, m_owner, m_cnt;
  logic [W-1:0] m_mem   [D];
  logic [BW-1:0] m_known [D];

  function automatic int model_pick(input logic [N-1:0] r);
    if (m_owner >= 0 && r[m_owner] && m_cnt < MB) return m_owner;
    for (int i = 0; i < N; i++)
      if (r[(m_rr + i) % N]) return (m_rr + i) % N;
    return -1;
  endfunction

  task automatic model_update(input logic [N-1:0] r, input logic [N-1:0] lk, input int w);
    bit was_locked;
    if (w < 0) return;
    was_locked = (m_owner >= 0 && r[m_owner] && m_cnt < MB);
    if (!was_locked) m_rr = (w + 1) % N;
    if (lk[w]) begin
      m_cnt   = was_locked ? m_cnt + 1 : 1;
      m_owner = w;
      if (m_cnt >= MB) begin
        m_owner = -1;
        m_cnt   = 0;
        m_rr    = (w + 1) % N;
      end
    end else begin
      m_owner = -1;
      m_cnt   = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    req = '0; lock = '0; we = '0; be = '0; addr = '0; wdata = '0;
  endtask

  task automatic set_port(input int p, input logic w, input logic [BW-1:0] b,
                          input logic [AW-1:0] a, input logic [W-1:0] d);
    we[p]             = w;
    be[p*BW +: BW]    = b;
    addr[p*AW +: AW]  = a;
    wdata[p*W +: W]   = d;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_rr = 0; m_owner = -1; m_cnt = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    req = 2'b11;
    @(negedge clk);
    #1;
    checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%b exp=00", gnt); end
    checks++; if (ram_cs_n !== 1'b1) begin failures++; $display("FAIL reset_cs_n got=%b exp=1", ram_cs_n); end
    checks++; if (ram_we_n !== 1'b1) begin failures++; $display("FAIL reset_we_n got=%b exp=1", ram_we_n); end
    checks++; if (ram_be_n !== 4'hf) begin failures++; $display("FAIL reset_be_n got=%h exp=f", ram_be_n); end
    checks++; if (rvalid !== 2'b00) begin failures++; $display("FAIL reset_rvalid got=%b exp=00", rvalid); end
    rst = 1'b0;
    #1;
    checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL reset_first_gnt got=%b exp=01", gnt); end
    tick();
  endtask

  task automatic test_contention();
    logic [1:0] exp_seq [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    apply_reset();
    req = 2'b11;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (gnt !== exp_seq[i]) begin
        failures++; $display("FAIL contention_gnt[%0d] got=%b exp=%b", i, gnt, exp_seq[i]);
      end
      tick();
    end
  endtask

  task automatic test_read_latency();
    apply_reset();
    req = 2'b10;
    set_port(1, 1'b1, 4'hf, 9'h010, 32'hDEADBEEF);
    #1;
    checks++; if (gnt !== 2'b10) begin failures++; $display("FAIL lat_wr_gnt got=%b exp=10", gnt); end
    checks++; if (ram_we_n !== 1'b0) begin failures++; $display("FAIL lat_wr_we_n got=%b exp=0", ram_we_n); end
    tick();
    set_port(1, 1'b0, 4'hf, 9'h010, 32'h0);
    #1;
    checks++; if (gnt !== 2'b10) begin failures++; $display("FAIL lat_rd_gnt got=%b exp=10", gnt); end
    checks++; if (rvalid !== 2'b00) begin failures++; $display("FAIL lat_wr_rvalid got=%b exp=00", rvalid); end
    tick();
    clear_inputs();
    #1;
    checks++; if (rvalid !== 2'b10) begin failures++; $display("FAIL lat_rvalid got=%b exp=10", rvalid); end
    checks++; if (rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL lat_rdata got=%h exp=deadbeef", rdata); end
    tick();
    checks++; if (rvalid !== 2'b00) begin failures++; $display("FAIL lat_rvalid_drop got=%b exp=00", rvalid); end
  endtask

  task automatic test_burst_lock();
    logic [1:0] exp_seq [6] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
    apply_reset();
    req  = 2'b11;
    lock = 2'b01;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (gnt !== exp_seq[i]) begin
        failures++; $display("FAIL burst_gnt[%0d] got=%b exp=%b", i, gnt, exp_seq[i]);
      end
      tick();
    end
  endtask

  task automatic test_byte_enables();
    apply_reset();
    req = 2'b01;
    set_port(0, 1'b1, 4'hf, 9'h020, 32'h11223344);
    tick();
    set_port(0, 1'b1, 4'b0101, 9'h020, 32'hAABBCCDD);
    #1;
    checks++; if (ram_be_n !== 4'b1010) begin failures++; $display("FAIL be_ram_be_n got=%b exp=1010", ram_be_n); end
    tick();
    set_port(0, 1'b0, 4'hf, 9'h020, 32'h0);
    tick();
    clear_inputs();
    #1;
    checks++; if (rvalid !== 2'b01) begin failures++; $display("FAIL be_rvalid got=%b exp=01", rvalid); end
    checks++; if (rdata !== 32'h11BB33DD) begin failures++; $display("FAIL be_rdata got=%h exp=11bb33dd", rdata); end
    tick();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req = 2'b01;
    set_port(0, 1'b0, 4'hf, 9'h000, 32'h0);
    tick();
    req  = 2'b10;
    lock = 2'b10;
    set_port(1, 1'b0, 4'hf, 9'h010, 32'h0);
    #1;
    checks++; if (gnt !== 2'b10) begin failures++; $display("FAIL mid_lock_gnt got=%b exp=10", gnt); end
    tick();
    checks++; if (rvalid !== 2'b10) begin failures++; $display("FAIL mid_pre_rvalid got=%b exp=10", rvalid); end
    rst  = 1'b1;
    req  = 2'b11;
    lock = 2'b00;
    #1;
    checks++; if (rvalid !== 2'b00) begin failures++; $display("FAIL mid_rvalid got=%b exp=00", rvalid); end
    checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL mid_gnt got=%b exp=00", gnt); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL mid_post_gnt got=%b exp=01", gnt); end
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0]  pv, pwe;
    logic [BW-1:0] pbe [N];
    logic [AW-1:0] pad [N];
    logic [W-1:0]  pdat [N];
    logic [N-1:0]  exp_rv;
    logic [W-1:0]  exp_rd, exp_mask;
    logic [N-1:0]  exp_g;
    int            w;
    apply_reset();
    pv = '0; pwe = '0; exp_rv = '0; exp_rd = '0; exp_mask = '0;
    for (int p = 0; p < N; p++) begin pbe[p] = '0; pad[p] = '0; pdat[p] = '0; end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int p = 0; p < N; p++) begin
        if (!pv[p] && $urandom_range(9) < 7) begin
          pv[p]   = 1'b1;
          pwe[p]  = 1'($urandom_range(1));
          pbe[p]  = BW'($urandom_range(15));
          pad[p]  = AW'($urandom_range(15));
          pdat[p] = $urandom;
        end
        lock[p] = ($urandom_range(9) < 4);
        req[p]  = pv[p];
        set_port(p, pwe[p], pbe[p], pad[p], pdat[p]);
      end
      #1;
      w = model_pick(req);
      exp_g = '0;
      if (w >= 0) exp_g[w] = 1'b1;
      checks++;
      if (gnt !== exp_g) begin failures++; $display("FAIL rnd_gnt c=%0d got=%b exp=%b", cyc, gnt, exp_g); end
      if (w >= 0) begin
        checks++;
        if (ram_cs_n !== 1'b0 || ram_we_n !== ~pwe[w] || ram_addr !== pad[w]) begin
          failures++;
          $display("FAIL rnd_ram c=%0d cs_n=%b we_n=%b addr=%h exp_we_n=%b exp_addr=%h",
                   cyc, ram_cs_n, ram_we_n, ram_addr, ~pwe[w], pad[w]);
        end
        if (pwe[w]) begin
          checks++;
          if (ram_be_n !== ~pbe[w] || ram_wdata !== pdat[w]) begin
            failures++;
            $display("FAIL rnd_wr c=%0d be_n=%b wdata=%h exp_be_n=%b exp_wdata=%h",
                     cyc, ram_be_n, ram_wdata, ~pbe[w], pdat[w]);
          end
        end
      end else begin
        checks++;
        if (ram_cs_n !== 1'b1 || ram_we_n !== 1'b1) begin
          failures++; $display("FAIL rnd_idle c=%0d cs_n=%b we_n=%b exp=1/1", cyc, ram_cs_n, ram_we_n);
        end
      end
      checks++;
      if (rvalid !== exp_rv) begin failures++; $display("FAIL rnd_rvalid c=%0d got=%b exp=%b", cyc, rvalid, exp_rv); end
      if (exp_rv != '0) begin
        checks++;
        if ((rdata & exp_mask) !== (exp_rd & exp_mask)) begin
          failures++; $display("FAIL rnd_rdata c=%0d got=%h exp=%h mask=%h", cyc, rdata, exp_rd, exp_mask);
        end
      end
      exp_rv = '0;
      if (w >= 0) begin
        if (pwe[w]) begin
          for (int b = 0; b < BW; b++)
            if (pbe[w][b]) begin
              m_mem[pad[w]][b*8 +: 8] = pdat[w][b*8 +: 8];
              m_known[pad[w]][b]      = 1'b1;
            end
        end else begin
          exp_rv[w] = 1'b1;
          exp_rd    = m_mem[pad[w]];
          for (int b = 0; b < BW; b++) exp_mask[b*8 +: 8] = {8{m_known[pad[w]][b]}};
        end
      end
      model_update(req, lock, w);
      if (w >= 0) pv[w] = 1'b0;
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    for (int a = 0; a < D; a++) begin
      m_known[a] = '0;
      m_mem[a]   = '0;
    end
    m_rr = 0; m_owner = -1; m_cnt = 0;
    test_reset();
    test_contention();
    test_read_latency();
    test_burst_lock();
    test_byte_enables();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
